// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//
// Generic pipeline-stage register with a valid/ready handshake and a 2-entry
// skid buffer. It stands in for the fixed IF/ID .. MEM/WB stage registers of
// the 5-stage CPU. Any stage payload is packed into a single DATA_W bus.
//
// The stage sustains one transfer per cycle under streaming. It absorbs one
// extra word when downstream stalls, so the upstream ready can be a flop.
// No combinational ready path crosses stage boundaries. A synchronous flush
// squashes every held entry and any word accepted in the same cycle.
//
// Optional feature macro: PIPE_STAGE_STATS_EN
//   When defined, this adds the stall_cnt and flush_cnt statistics ports and
//   their saturating counters. When undefined, those ports do not exist and
//   all other behaviour is unchanged.
//
// Parameters:
//   DATA_W     payload width in bits (default 104 = MEM/WB bundle)
//   CNT_W      statistics counter width (only used with PIPE_STAGE_STATS_EN)
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   upstream payload valid
//   in_ready   stage can accept a word (registered)
//   in_data    upstream payload
//   flush      synchronous squash of all held and incoming entries
//   out_valid  downstream payload valid
//   out_ready  downstream accepts
//   out_data   downstream payload (registered, zero while out_valid is low)
//   occupancy  entries currently held: 0, 1 or 2
//   stall_cnt  [stats] cycles with out_valid & !out_ready & !flush
//   flush_cnt  [stats] valid entries discarded by flush
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 104,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  // Elaboration-time sanity checks on the configuration.
  if (DATA_W < 1) begin : g_bad_data_w
    $error("pipe_stage_skid: DATA_W must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipe_stage_skid: CNT_W must be at least 1");
  end

  // The state encoding matches the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] main_next;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] skid_next;
  logic              ready_reg;
  logic              ready_next;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & ready_reg;
  assign out_fire = out_valid & out_ready;

  // State, data and ready registers.
  // Reset empties the stage and holds ready low until the first edge after
  // reset is released.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      main_data <= '0;
      skid_data <= '0;
      ready_reg <= 1'b0;
    end else begin
      state     <= state_next;
      main_data <= main_next;
      skid_data <= skid_next;
      ready_reg <= ready_next;
    end
  end

  // Next-state and next-data logic.
  // The main register always holds the oldest entry. The skid register is
  // only filled when a word arrives while the main entry is stalled, which
  // keeps the order strictly FIFO.
  // While FULL, ready_reg is low, so no word can arrive in that state.
  // Flush overrides everything. A word accepted in the flush cycle completes
  // its handshake but is dropped.
  always_comb begin
    state_next = state;
    main_next  = main_data;
    skid_next  = skid_data;

    if (flush) begin
      state_next = EMPTY;
      main_next  = '0;
      skid_next  = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_next  = in_data;
            state_next = ONE;
          end
        end

        ONE: begin
          if (in_fire && out_fire) begin
            main_next = in_data;
          end else if (in_fire) begin
            skid_next  = in_data;
            state_next = FULL;
          end else if (out_fire) begin
            main_next  = '0;
            state_next = EMPTY;
          end
        end

        FULL: begin
          if (out_fire) begin
            main_next  = skid_data;
            skid_next  = '0;
            state_next = ONE;
          end
        end

        default: begin
          state_next = EMPTY;
          main_next  = '0;
          skid_next  = '0;
        end
      endcase
    end

    // Ready is derived from the next state only, never from out_ready.
    ready_next = (state_next != FULL);
  end

  // Output decode from the registered state.
  always_comb begin
    in_ready  = ready_reg;
    out_data  = main_data;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state)
      ONE: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      FULL: begin
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: begin
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
    endcase
  end

`ifdef PIPE_STAGE_STATS_EN
  // The sums carry one extra bit so that overflow can be seen and clamped
  // to all-ones.
  // flush_drop counts the entries a flush discards:
  //   - the held entries,
  //   - minus one leaving downstream in the same cycle,
  //   - plus a word accepted in the same cycle.
  logic [2:0]     flush_drop;
  logic [CNT_W:0] stall_sum;
  logic [CNT_W:0] flush_sum;

  always_comb begin
    flush_drop = {1'b0, occupancy} - {2'b00, out_fire} + {2'b00, in_fire};
    stall_sum  = {1'b0, stall_cnt} + (CNT_W+1)'(1);
    flush_sum  = {1'b0, flush_cnt} + (CNT_W+1)'(flush_drop);
  end

  // Saturating statistics counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && !flush)
        stall_cnt <= stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
      if (flush)
        flush_cnt <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
    end
  end
`endif

endmodule
